// File: rtl/ks10_irfetch_pkg.sv
// KS10 instruction-register fetch controller: shared FSM encoding
// and default non-existent-memory timeout.
package ks10_irfetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2
  } irfState_t;

  localparam int TIMEOUT_DEF = 127;

endpackage

// File: rtl/irf_timer.sv
// Fetch timeout counter; expire flags the WAIT cycle whose
// increment would reach TIMEOUT.
module irf_timer
  import ks10_irfetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clken,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clken) begin
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        count <= count + 8'd1;
      end
    end
  end

  assign expire = inc && (count == LAST);

endmodule

// File: rtl/ir_fetch_ctl.sv
// Instruction fetch sequencer: reads one word from memory into the
// IR bus, pulses the load strobes, and flags memory timeouts.
module ir_fetch_ctl
  import ks10_irfetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clken,
  input  logic         fetchREQ,
  input  logic         abort,
  input  logic [18:35] pc,
  input  logic         memACK,
  input  logic [0:35]  memDATA,
  input  logic         nxmCLR,
  output logic         memREQ,
  output logic [18:35] memADDR,
  output logic [0:35]  irDATA,
  output logic         loadIR,
  output logic         loadXR,
  output logic         busy,
  output logic         done,
  output logic         nxmERR
);

  irfState_t state;
  irfState_t nextState;

  logic start;
  logic capture;
  logic tmoSet;
  logic inc;
  logic expire;

  // Abort suppresses counting so a cancelled fetch never times out.
  assign inc = (state == WAIT) && !memACK && !abort;

  irf_timer #(
    .TIMEOUT(TIMEOUT)
  ) uTimer (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .clr   (start),
    .inc   (inc),
    .expire(expire)
  );

  always_comb begin
    nextState = state;
    start     = 1'b0;
    capture   = 1'b0;
    tmoSet    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetchREQ && !abort) begin
          start     = 1'b1;
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          nextState = IDLE;
        end else if (memACK) begin
          capture   = 1'b1;
          nextState = LOAD;
        end else if (expire) begin
          tmoSet    = 1'b1;
          nextState = IDLE;
        end
      end
      LOAD:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (clken) begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memADDR <= '0;
      irDATA  <= '0;
      nxmERR  <= 1'b0;
    end else if (clken) begin
      if (start) begin
        memADDR <= pc;
      end
      if (capture) begin
        irDATA <= memDATA;
      end
      if (tmoSet) begin
        nxmERR <= 1'b1;
      end else if (start || nxmCLR) begin
        nxmERR <= 1'b0;
      end
    end
  end

  assign memREQ = (state == WAIT);
  assign loadIR = (state == LOAD);
  assign loadXR = (state == LOAD);
  assign done   = (state == LOAD);
  assign busy   = (state != IDLE);

endmodule

// File: doc/ir_fetch_ctl.md
IR_FETCH_CTL -- requirements
Module: ir_fetch_ctl

Interface
REQ-001 Parameter TIMEOUT, default 127, SHALL set the number of clken cycles in WAIT before a non-existent-memory abort; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 clken  input  1  SHALL be the clock enable; state SHALL advance only when high.
REQ-005 fetchREQ  input  1  SHALL be the microcode request to fetch an instruction word.
REQ-006 abort  input  1  SHALL cancel any fetch in progress (page fail or interrupt).
REQ-007 pc  input  18 [18:35]  SHALL be the fetch address, sampled on fetch start.
REQ-008 memACK  input  1  SHALL be the memory read acknowledge.
REQ-009 memDATA  input  36 [0:35]  SHALL be the read data, valid with memACK.
REQ-010 nxmCLR  input  1  SHALL clear the sticky error flag.
REQ-011 memREQ  output  1  SHALL be the memory read request.
REQ-012 memADDR  output  18 [18:35]  SHALL be the latched fetch address.
REQ-013 irDATA  output  36 [0:35]  SHALL be the captured instruction word, driven to the IR input bus.
REQ-014 loadIR, loadXR  output  1 each  SHALL be the IR opcode/AC and index/indirect load strobes.
REQ-015 busy  output  1  SHALL be high in any state other than IDLE.
REQ-016 done  output  1  SHALL pulse for one clken cycle when a fetch completes.
REQ-017 nxmERR  output  1  SHALL be the sticky fetch-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, WAIT and LOAD; every transition SHALL require clken high.
REQ-019 IDLE with fetchREQ SHALL latch pc into memADDR, clear the timeout counter, clear nxmERR and enter WAIT.
REQ-020 memREQ SHALL be high exactly while the state is WAIT; memADDR SHALL stay stable throughout WAIT.
REQ-021 WAIT with memACK SHALL capture memDATA into irDATA and enter LOAD.
REQ-022 WAIT without memACK SHALL increment the 8-bit timeout counter.
REQ-023 When the counter equals TIMEOUT without memACK, the block SHALL set nxmERR and enter IDLE without asserting a load strobe.
REQ-024 If memACK and the timeout occur in the same cycle, memACK SHALL win.
REQ-025 LOAD SHALL assert loadIR, loadXR and done together for exactly one clken cycle, then enter IDLE.
REQ-026 Minimum latency SHALL be fetchREQ cycle N -> WAIT N+1 -> memACK at N+1 -> strobes at N+2 -> IDLE at N+3.
REQ-027 abort SHALL force IDLE on the next clken edge from any state and SHALL have priority over memACK, the timeout and LOAD; no strobe or done SHALL follow.
REQ-028 fetchREQ outside IDLE, and memACK outside WAIT, SHALL be ignored.
REQ-029 When clken is low, the state, counter, irDATA, memREQ and the strobes SHALL hold their values. Strobes SHALL only ever be qualified with clken by the consumer.
REQ-030 nxmCLR SHALL clear nxmERR; if a timeout sets it in the same cycle, the set SHALL win.
REQ-031 irDATA SHALL retain the last captured word until the next memACK in WAIT.

Reset
REQ-032 rst SHALL asynchronously force the state to IDLE and clear the counter, memADDR, irDATA and nxmERR; all outputs SHALL be 0.
REQ-033 rst asserted mid-fetch SHALL drop memREQ immediately, independent of clk and clken.

Structure
REQ-034 A shared package ks10_irfetch_pkg SHALL hold the FSM state encoding and the default TIMEOUT constant.
REQ-035 The timeout counter SHALL be a sub-module irf_timer with ports clk, rst, clken, clr, inc, expire and parameter TIMEOUT.

Verification
REQ-036 pc=0o001000, fetchREQ, memACK one cycle later with memDATA=0o254000_000000 -> memADDR=0o001000; loadIR, loadXR and done at N+2; irDATA=0o254000000000.
REQ-037 TIMEOUT=4, no memACK -> memREQ high for 4 cycles, then nxmERR=1, busy=0, no strobes; the next fetchREQ clears nxmERR.
REQ-038 abort and memACK in the same WAIT cycle -> IDLE, irDATA unchanged, no done.
REQ-039 clken toggling 1/0 during WAIT, memACK on an enabled cycle -> counter and state advance only on enabled cycles; one strobe pulse.
REQ-040 rst pulsed mid-WAIT with no clk edge -> memREQ=0 and busy=0 immediately; all outputs 0.
REQ-041 fetchREQ held high through a full fetch -> a second fetch starts from IDLE only after LOAD, with no overlap.
